uart_time_sender: RTL

//  Formats a 6-digit BCD time snapshot as the 10-byte ASCII line "HH:MM:SS\r\n".

---
 rtl/uart_time_sender.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_time_sender.sv
// uart_time_sender: turns a BCD time snapshot into the ASCII line "HH:MM:SS\r\n" and
// streams it byte by byte through the UART transmit handshake, aborting on a missing tx_done.
module uart_time_sender #(
   parameter int DATA_WIDTH = 8,
   parameter int TO_CYCLES  = 200000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  send,
   input  logic [23:0]           time_bcd,
   input  logic                  tx_done,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_start,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT,
      S_NEXT,
      S_FINISH
   } state_t;

   state_t                  state_q;
   logic [3:0]              idx_q;
   logic [23:0]             snap_q;
   logic [CW-1:0]           cnt_q;
   logic [DATA_WIDTH-1:0]   tx_data_q;
   logic                    tx_start_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    err_q;
   logic [7:0]              byte_d;

   function automatic logic [7:0] to_ascii(input logic [3:0] digit);
      return (digit <= 4'd9) ? (8'h30 + {4'h0, digit}) : 8'h3F;
   endfunction

   always_comb begin
      byte_d = 8'h0A;
      case (idx_q)
         4'd0:    byte_d = to_ascii(snap_q[23:20]);
         4'd1:    byte_d = to_ascii(snap_q[19:16]);
         4'd2:    byte_d = 8'h3A;
         4'd3:    byte_d = to_ascii(snap_q[15:12]);
         4'd4:    byte_d = to_ascii(snap_q[11:8]);
         4'd5:    byte_d = 8'h3A;
         4'd6:    byte_d = to_ascii(snap_q[7:4]);
         4'd7:    byte_d = to_ascii(snap_q[3:0]);
         4'd8:    byte_d = 8'h0D;
         default: byte_d = 8'h0A;
      endcase
   end

   // tx_start and done are single-cycle pulses: cleared every cycle unless re-armed below.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         snap_q     <= '0;
         cnt_q      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (send) begin
                  snap_q  <= time_bcd;
                  idx_q   <= '0;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               tx_data_q  <= DATA_WIDTH'(byte_d);
               tx_start_q <= 1'b1;
               state_q    <= S_START;
            end
            S_START: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // Counter only advances below its terminal value, so it can never wrap.
               if (tx_done) begin
                  state_q <= S_NEXT;
               end else if (cnt_q == CNT_LAST) begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_FINISH;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_NEXT: begin
               if (idx_q == 4'd9) begin
                  done_q  <= 1'b1;
                  state_q <= S_FINISH;
               end else begin
                  idx_q   <= idx_q + 4'd1;
                  state_q <= S_LOAD;
               end
            end
            S_FINISH: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule
